// File: rtl/arp_rx.sv
// arp_rx: GMII receive-side ARP parser; reports sender MAC/IP of ARP requests/replies targeting this board.
module arp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END} state_t;
  state_t state, state_nx;
  logic [4:0]  cnt;
  logic [39:0] sr;
  logic [47:0] sr_nx;
  logic [47:0] sha;
  logic [31:0] spa;
  logic [15:0] oper;
  logic        dst_ok;
  logic        eth_pass;
  logic        arp_pass;
  // sr_nx always holds the most recent six bytes including the current one
  assign sr_nx    = {sr, gmii_rxd};
  assign eth_pass = dst_ok && sr_nx[15:0] == 16'h0806;
  assign arp_pass = sr_nx[31:0] == BOARD_IP && (oper == 16'd1 || oper == 16'd2);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = !gmii_rx_dv ? IDLE : gmii_rxd == 8'h55 ? PREAMBLE : RX_END;
      PREAMBLE: state_nx = !gmii_rx_dv ? IDLE :
                           cnt < 5'd7 ? (gmii_rxd == 8'h55 ? PREAMBLE : RX_END) :
                                        (gmii_rxd == 8'hd5 ? ETH_HEAD : RX_END);
      ETH_HEAD: state_nx = !gmii_rx_dv ? IDLE : cnt == 5'd13 ? (eth_pass ? ARP_DATA : RX_END) : ETH_HEAD;
      ARP_DATA: state_nx = !gmii_rx_dv ? IDLE : cnt == 5'd27 ? RX_END : ARP_DATA;
      default:  state_nx = !gmii_rx_dv ? IDLE : RX_END;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= state_nx != state ? (state_nx == PREAMBLE ? 5'd1 : 5'd0) :
               gmii_rx_dv ? cnt + 5'd1 : cnt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= '0;
      sha         <= '0;
      spa         <= '0;
      oper        <= '0;
      dst_ok      <= 1'b0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      arp_rx_done <= 1'b0;
      if (gmii_rx_dv && (state == ETH_HEAD || state == ARP_DATA)) sr <= sr_nx[39:0];
      if (gmii_rx_dv && state == ETH_HEAD && cnt == 5'd5) dst_ok <= sr_nx == BOARD_MAC || sr_nx == '1;
      if (gmii_rx_dv && state == ARP_DATA) begin
        if (cnt == 5'd7)  oper <= sr_nx[15:0];
        if (cnt == 5'd13) sha  <= sr_nx;
        if (cnt == 5'd17) spa  <= sr_nx[31:0];
        if (cnt == 5'd27 && arp_pass) begin
          arp_rx_done <= 1'b1;
          arp_rx_type <= oper == 16'd2;
          src_mac     <= sha;
          src_ip      <= spa;
        end
      end
    end
  end
endmodule
